// File: rtl/wakey_wakey_pkg.sv
// Shared types and default widths for the wakey_wakey PDM microphone front end.
package wakey_wakey_pkg;

  localparam int DEF_DIV_W    = 8;
  localparam int DEF_SETTLE_W = 16;
  localparam int DEF_HANG_W   = 20;

  // Encodings are visible on state_o, so they are pinned explicitly.
  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    HANG   = 2'd3
  } mic_state_t;

  // Sampled PDM bits are only forwarded downstream in these states.
  function automatic logic is_streaming(input mic_state_t s);
    return (s == RUN) || (s == HANG);
  endfunction

endpackage

// File: rtl/pdm_clk_div.sv
// Half-period divider for the PDM mic clock: a counter plus a toggle flop.
// fall_o is high in the cycle whose closing edge drives pdm_clk_o from 1 to 0.
module pdm_clk_div
  import wakey_wakey_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             pdm_clk_o,
  output logic             fall_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] last_c;
  logic             clk_q, clk_d;
  logic             term_c;

  // Next count/phase; a divide of 0 behaves as 1. The >= compare keeps the
  // counter from running past a terminal that shrank while the divider ran.
  always_comb begin
    last_c = (div_i == '0) ? '0 : div_i - 1'b1;
    term_c = (cnt_q >= last_c);
    cnt_d  = cnt_q + 1'b1;
    clk_d  = clk_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (term_c) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end
  end

  assign fall_o    = en_i & ~clr_i & term_c & clk_q;
  assign pdm_clk_o = clk_q;

  // Counter and clock phase registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

endmodule

// File: rtl/pdm_mic_ctrl.sv
// PDM microphone sequencer: wakes the mic clock on voice activity, drops the
// startup-settling bits, streams sampled bits and holds the clock for a hang
// time after activity stops.
// Build option PDM_CLK_GATE_EN: when defined the mic clock only runs outside
// OFF and every start goes through SETTLE; when undefined the divider runs
// whenever the block is enabled and OFF goes straight to RUN.
module pdm_mic_ctrl
  import wakey_wakey_pkg::*;
#(
  parameter int DIV_W    = DEF_DIV_W,
  parameter int SETTLE_W = DEF_SETTLE_W,
  parameter int HANG_W   = DEF_HANG_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_en_i,
  input  logic [DIV_W-1:0]    cfg_div_i,
  input  logic [SETTLE_W-1:0] cfg_settle_i,
  input  logic [HANG_W-1:0]   cfg_hang_i,
  input  logic                vad_i,
  input  logic                pdm_data_i,
  output logic                pdm_clk_o,
  output logic                pdm_data_o,
  output logic                pdm_valid_o,
  output logic [1:0]          state_o
);

`ifdef PDM_CLK_GATE_EN
  localparam bit GATE_EN = 1'b1;
`else
  localparam bit GATE_EN = 1'b0;
`endif

  logic [1:0]          vad_sync_q;
  logic                vad_s;
  mic_state_t          state_q;
  logic [DIV_W-1:0]    div_q;
  logic [SETTLE_W-1:0] settle_q, settle_cnt_q;
  logic [HANG_W-1:0]   hang_q, hang_cnt_q;
  logic                data_q, valid_q;
  logic                leave_c;
  logic                div_clr;
  logic                fall;
  logic [DIV_W-1:0]    div_sel;

  assign vad_s = vad_sync_q[1];

  // Two-flop synchroniser for the asynchronous pad VAD.
  always_ff @(posedge clk_i) begin
    if (rst_i) vad_sync_q <= '0;
    else       vad_sync_q <= {vad_sync_q[0], vad_i};
  end

  // Streaming states about to fall back to OFF this cycle; the gated clock
  // is dropped on the same edge the state changes.
  always_comb begin
    leave_c = 1'b0;
    case (state_q)
      RUN:     leave_c = !vad_s && (hang_q == '0);
      HANG:    leave_c = !vad_s && (hang_cnt_q <= HANG_W'(1));
      default: leave_c = 1'b0;
    endcase
  end

  // Live divide in OFF (only matters when the clock free-runs), latched otherwise.
  assign div_sel = (state_q == OFF) ? cfg_div_i : div_q;
  assign div_clr = GATE_EN && ((state_q == OFF) || leave_c);

  pdm_clk_div #(.DIV_W(DIV_W)) u_div (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (cfg_en_i),
    .clr_i    (div_clr),
    .div_i    (div_sel),
    .pdm_clk_o(pdm_clk_o),
    .fall_o   (fall)
  );

  // Power sequencing FSM with config shadow registers and settle/hang counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= OFF;
      div_q        <= '0;
      settle_q     <= '0;
      hang_q       <= '0;
      settle_cnt_q <= '0;
      hang_cnt_q   <= '0;
    end else if (!cfg_en_i) begin
      state_q      <= OFF;
      settle_cnt_q <= '0;
      hang_cnt_q   <= '0;
    end else begin
      case (state_q)
        OFF: begin
          settle_cnt_q <= '0;
          hang_cnt_q   <= '0;
          if (vad_s) begin
            div_q    <= cfg_div_i;
            settle_q <= cfg_settle_i;
            hang_q   <= cfg_hang_i;
            state_q  <= GATE_EN ? SETTLE : RUN;
          end
        end
        SETTLE: begin
          if (settle_q == '0) begin
            state_q <= RUN;
          end else if (fall) begin
            if (settle_cnt_q == settle_q - 1'b1) begin
              settle_cnt_q <= '0;
              state_q      <= RUN;
            end else begin
              settle_cnt_q <= settle_cnt_q + 1'b1;
            end
          end
        end
        RUN: begin
          if (!vad_s) begin
            if (hang_q == '0) begin
              state_q <= OFF;
            end else begin
              state_q    <= HANG;
              hang_cnt_q <= hang_q;
            end
          end
        end
        HANG: begin
          if (vad_s) begin
            state_q    <= RUN;
            hang_cnt_q <= '0;
          end else if (leave_c) begin
            state_q    <= OFF;
            hang_cnt_q <= '0;
          end else begin
            hang_cnt_q <= hang_cnt_q - 1'b1;
          end
        end
        default: state_q <= OFF;
      endcase
    end
  end

  // Sample the mic on each clock fall; strobe valid only while streaming.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= fall && is_streaming(state_q);
      if (fall) data_q <= pdm_data_i;
    end
  end

  assign pdm_data_o  = data_q;
  assign pdm_valid_o = valid_q;
  assign state_o     = state_q;

endmodule
